// File: rtl/mem_port_scheduler.sv
// Shares one single-port SRAM between an instruction-fetch port and a data-memory port.
// Latency: grant and SRAM access are in the same cycle; read data returns one cycle after the grant.
// Backpressure: the requester that loses arbitration holds its request until granted; round-robin on conflict.
module mem_port_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_err,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_ceb,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} state_t;

  // last_gnt encoding: which port was served last
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   dm_legal;
  logic   dm_win;

  // Address bits outside the word-address window carry no meaning here
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2]};

  // Decide whether the DM request is naturally aligned and of a legal size
  always_comb begin
    dm_legal = 1'b0;
    case (dm_size)
      2'b00:   dm_legal = 1'b1;
      2'b01:   dm_legal = ~dm_addr[0];
      2'b10:   dm_legal = (dm_addr[1:0] == 2'b00);
      default: dm_legal = 1'b0;
    endcase
  end

  // Round-robin arbitration, grant/error generation and next read-outstanding state
  always_comb begin
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    dm_err     = 1'b0;
    dm_win     = 1'b0;
    state_d    = IDLE;
    last_gnt_d = last_gnt_q;
    if (!rst) begin
      // An illegal DM request still wins its turn; it is answered with dm_err instead of an access
      dm_win = dm_req && (!if_req || (last_gnt_q == GNT_IF));
      if (dm_win) begin
        last_gnt_d = GNT_DM;
        if (dm_legal) begin
          dm_gnt = 1'b1;
          if (!dm_we) state_d = RD_DM;
        end else begin
          dm_err = 1'b1;
        end
      end else if (if_req) begin
        if_gnt     = 1'b1;
        last_gnt_d = GNT_IF;
        state_d    = RD_IF;
      end
    end
  end

  // SRAM command for the granted access: word address, byte-lane write enables and lane-aligned data
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 4'b1111;
    sram_a   = '0;
    sram_di  = '0;
    if (if_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = if_addr[ADDR_W+1:2];
    end else if (dm_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = dm_addr[ADDR_W+1:2];
      if (dm_we) begin
        case (dm_size)
          2'b00: begin
            sram_web = ~(4'b0001 << dm_addr[1:0]);
            sram_di  = DATA_W'(dm_wdata[7:0]) << {dm_addr[1:0], 3'b000};
          end
          2'b01: begin
            sram_web = dm_addr[1] ? 4'b0011 : 4'b1100;
            sram_di  = DATA_W'(dm_wdata[15:0]) << {dm_addr[1], 4'b0000};
          end
          default: begin
            sram_web = 4'b0000;
            sram_di  = dm_wdata;
          end
        endcase
      end
    end
  end

  // Read data is the raw SRAM word; the state register says whose it is
  always_comb begin
    if_rvalid = (state_q == RD_IF) && !rst;
    dm_rvalid = (state_q == RD_DM) && !rst;
    if_rdata  = sram_do;
    dm_rdata  = sram_do;
  end

  // State and round-robin pointer; reset drops any outstanding read and favours DM first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_IF;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Bench for mem_port_scheduler: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic checked against a behavioural model of the arbitration rules.
// Inputs are driven 1 ns after the rising edge and outputs sampled on the falling edge.
module tb_mem_port_scheduler;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] sram_do;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_dm_err;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic        e_ceb;
    logic [3:0]  e_web;
    logic [13:0] e_a;
    logic [31:0] e_di;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [1:0]  dm_size = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] sram_do = '0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_err, dm_rvalid, sram_ceb;
  logic [31:0] if_rdata, dm_rdata, sram_di;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: who was served last, and which read is outstanding (0 none, 1 IF, 2 DM)
  bit m_last_dm = 1'b0;
  int m_pend = 0;

  always #5 clk = ~clk;

  mem_port_scheduler #(.DATA_W(32), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_err(dm_err), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  function automatic vec_t idle_v();
    vec_t v;
    v.rst = 0; v.if_req = 0; v.if_addr = '0; v.dm_req = 0; v.dm_we = 0; v.dm_size = '0;
    v.dm_addr = '0; v.dm_wdata = '0; v.sram_do = 32'h0BAD_F00D;
    v.e_if_gnt = 0; v.e_dm_gnt = 0; v.e_dm_err = 0; v.e_if_rv = 0; v.e_dm_rv = 0;
    v.e_ceb = 1; v.e_web = 4'b1111; v.e_a = '0; v.e_di = '0;
    return v;
  endfunction

  // Fill in expectations from the access rules and the model state, then advance the model
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int nb, off, mask;
    bit legal, dm_turn;
    v.e_if_gnt = 0; v.e_dm_gnt = 0; v.e_dm_err = 0; v.e_ceb = 1; v.e_web = 4'b1111; v.e_a = '0; v.e_di = '0;
    v.e_if_rv = !v.rst && (m_pend == 1);
    v.e_dm_rv = !v.rst && (m_pend == 2);
    dm_turn = 0;
    if (!v.rst) begin
      nb      = 1 << v.dm_size;
      off     = v.dm_addr % 4;
      legal   = (v.dm_size != 2'd3) && (off % nb == 0);
      dm_turn = v.dm_req && (!v.if_req || !m_last_dm);
      if (dm_turn && legal) begin
        v.e_dm_gnt = 1; v.e_ceb = 0; v.e_a = 14'(v.dm_addr >> 2);
        if (v.dm_we) begin
          mask    = ((1 << nb) - 1) << off;
          v.e_web = ~mask[3:0];
          v.e_di  = v.dm_wdata << (8 * off);
        end
      end else if (dm_turn) begin
        v.e_dm_err = 1;
      end else if (v.if_req) begin
        v.e_if_gnt = 1; v.e_ceb = 0; v.e_a = 14'(v.if_addr >> 2);
      end
    end
    if (v.rst) begin
      m_pend = 0; m_last_dm = 0;
    end else begin
      m_pend = v.e_if_gnt ? 1 : (v.e_dm_gnt && !v.dm_we) ? 2 : 0;
      if (dm_turn) m_last_dm = 1;
      else if (v.if_req) m_last_dm = 0;
    end
    return v;
  endfunction

  // Apply one cycle of inputs and compare every output against the vector's expectations
  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] m;
    bit ok;
    @(posedge clk); #1;
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; dm_req = v.dm_req; dm_we = v.dm_we;
    dm_size = v.dm_size; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata; sram_do = v.sram_do;
    @(negedge clk);
    m  = {{8{~v.e_web[3]}}, {8{~v.e_web[2]}}, {8{~v.e_web[1]}}, {8{~v.e_web[0]}}};
    ok = (if_gnt === v.e_if_gnt) && (dm_gnt === v.e_dm_gnt) && (dm_err === v.e_dm_err) &&
         (if_rvalid === v.e_if_rv) && (dm_rvalid === v.e_dm_rv) && (sram_ceb === v.e_ceb) &&
         (sram_web === v.e_web);
    if (!v.e_ceb && sram_a !== v.e_a) ok = 0;
    if (((sram_di & m) !== (v.e_di & m))) ok = 0;
    if (v.e_if_rv && if_rdata !== v.sram_do) ok = 0;
    if (v.e_dm_rv && dm_rdata !== v.sram_do) ok = 0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got gnt(if,dm)=%b%b err=%b rv(if,dm)=%b%b ceb=%b web=%b a=%h di=%h rd(if,dm)=%h/%h; want gnt=%b%b err=%b rv=%b%b ceb=%b web=%b a=%h di=%h rd=%h",
               nm, if_gnt, dm_gnt, dm_err, if_rvalid, dm_rvalid, sram_ceb, sram_web, sram_a, sram_di & m,
               if_rdata, dm_rdata, v.e_if_gnt, v.e_dm_gnt, v.e_dm_err, v.e_if_rv, v.e_dm_rv, v.e_ceb,
               v.e_web, v.e_a, v.e_di & m, v.sram_do);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [13:0] a);
    return {16'(a) ^ 16'hC0DE, 16'(a)};
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;
    int n_if, n_dm;
    bit if_pend, dm_pend;
    vec_t ifr, dmr;

    // ---------------- directed table ----------------
    v = idle_v(); v.rst = 1; v.if_req = 1; v.if_addr = 32'h100; v.dm_req = 1; v.dm_size = 2; v.dm_addr = 32'h200; tbl.push_back(v);
    v = idle_v(); v.rst = 1; tbl.push_back(v);
    // conflict right after reset: DM first, then IF
    v = idle_v(); v.if_req = 1; v.if_addr = 32'h100; v.dm_req = 1; v.dm_size = 2; v.dm_addr = 32'h200;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_a = 14'h80; tbl.push_back(v);
    v = idle_v(); v.if_req = 1; v.if_addr = 32'h100; v.sram_do = 32'h1111_2222;
    v.e_if_gnt = 1; v.e_ceb = 0; v.e_a = 14'h40; v.e_dm_rv = 1; tbl.push_back(v);
    v = idle_v(); v.sram_do = 32'h3333_4444; v.e_if_rv = 1; tbl.push_back(v);
    // stores
    v = idle_v(); v.dm_req = 1; v.dm_we = 1; v.dm_size = 0; v.dm_addr = 32'h7; v.dm_wdata = 32'hA5;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_web = 4'b0111; v.e_di = 32'hA500_0000; v.e_a = 14'h1; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_we = 1; v.dm_size = 1; v.dm_addr = 32'h2; v.dm_wdata = 32'h1234;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_web = 4'b0011; v.e_di = 32'h1234_0000; v.e_a = 14'h0; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_we = 1; v.dm_size = 1; v.dm_addr = 32'h3; v.dm_wdata = 32'h1234;
    v.e_dm_err = 1; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_size = 2; v.dm_addr = 32'h2; v.e_dm_err = 1; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_size = 3; v.dm_addr = 32'h0; v.e_dm_err = 1; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_we = 1; v.dm_size = 2; v.dm_addr = 32'h10; v.dm_wdata = 32'hDEAD_BEEF;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_web = 4'b0000; v.e_di = 32'hDEAD_BEEF; v.e_a = 14'h4; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_we = 1; v.dm_size = 1; v.dm_addr = 32'h20; v.dm_wdata = 32'hBEEF;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_web = 4'b1100; v.e_di = 32'h0000_BEEF; v.e_a = 14'h8; tbl.push_back(v);
    // load outstanding then reset: no rvalid
    v = idle_v(); v.dm_req = 1; v.dm_size = 2; v.dm_addr = 32'h40; v.e_dm_gnt = 1; v.e_ceb = 0; v.e_a = 14'h10; tbl.push_back(v);
    v = idle_v(); v.rst = 1; v.dm_req = 1; v.dm_size = 2; v.dm_addr = 32'h44; tbl.push_back(v);
    v = idle_v(); tbl.push_back(v);
    // error consumes the DM turn, IF then wins the next conflict
    v = idle_v(); v.if_req = 1; v.if_addr = 32'h300; v.dm_req = 1; v.dm_we = 1; v.dm_size = 2; v.dm_addr = 32'h1;
    v.e_dm_err = 1; tbl.push_back(v);
    v = idle_v(); v.if_req = 1; v.if_addr = 32'h300; v.dm_req = 1; v.dm_size = 0; v.dm_addr = 32'h9;
    v.e_if_gnt = 1; v.e_ceb = 0; v.e_a = 14'hC0; tbl.push_back(v);
    v = idle_v(); v.dm_req = 1; v.dm_size = 0; v.dm_addr = 32'h9; v.sram_do = 32'hCAFE_0001;
    v.e_dm_gnt = 1; v.e_ceb = 0; v.e_a = 14'h2; v.e_if_rv = 1; tbl.push_back(v);
    v = idle_v(); v.sram_do = 32'h0000_7777; v.e_dm_rv = 1; tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("table[%0d]", i));

    // ---------------- fetch streaming every cycle ----------------
    v = idle_v(); v.rst = 1; run_vec(v, "stream_rst");
    for (int i = 0; i < 8; i++) begin
      v = idle_v(); v.if_req = 1; v.if_addr = 32'h400 + 32'(4 * i);
      v.sram_do = (i > 0) ? pattern(14'(32'h100 + i - 1)) : 32'h0;
      v.e_if_gnt = 1; v.e_ceb = 0; v.e_a = 14'(32'h100 + i); v.e_if_rv = (i > 0);
      run_vec(v, $sformatf("stream[%0d]", i));
    end
    v = idle_v(); v.sram_do = pattern(14'h107); v.e_if_rv = 1; run_vec(v, "stream_tail");

    // ---------------- continuous dual requests: strict alternation ----------------
    v = idle_v(); v.rst = 1; run_vec(v, "alt_rst");
    n_if = 0; n_dm = 0;
    for (int i = 0; i < 10; i++) begin
      v = idle_v(); v.if_req = 1; v.if_addr = 32'h800 + 32'(4 * i);
      v.dm_req = 1; v.dm_we = 1; v.dm_size = 2; v.dm_addr = 32'h80 + 32'(4 * i); v.dm_wdata = 32'h5500_0000 + 32'(i);
      v.sram_do = 32'hABC0_0000 + 32'(i);
      v.e_ceb = 0; v.e_if_rv = (i > 0) && (i % 2 == 0);
      if (i % 2 == 0) begin
        v.e_dm_gnt = 1; v.e_web = 4'b0000; v.e_di = v.dm_wdata; v.e_a = 14'(v.dm_addr >> 2);
      end else begin
        v.e_if_gnt = 1; v.e_a = 14'(v.if_addr >> 2);
      end
      run_vec(v, $sformatf("alt[%0d]", i));
      n_if += int'(if_gnt); n_dm += int'(dm_gnt);
    end
    v = idle_v(); v.e_if_rv = 1; run_vec(v, "alt_tail");
    n_vec++; if (n_if != 5) begin n_bad++; $display("FAIL alt_if_count: got %0d, want 5", n_if); end
    n_vec++; if (n_dm != 5) begin n_bad++; $display("FAIL alt_dm_count: got %0d, want 5", n_dm); end

    // ---------------- randomized traffic vs. model ----------------
    if_pend = 0; dm_pend = 0; ifr = idle_v(); dmr = idle_v();
    for (int c = 0; c < 400; c++) begin
      if (!if_pend && $urandom_range(0, 9) < 6) begin
        if_pend = 1; ifr.if_addr = $urandom_range(0, 16'hFFFF);
      end
      if (!dm_pend && $urandom_range(0, 9) < 6) begin
        dm_pend = 1; dmr.dm_we = 1'($urandom_range(0, 1)); dmr.dm_size = 2'($urandom_range(0, 3));
        dmr.dm_addr = $urandom_range(0, 255); dmr.dm_wdata = $urandom;
      end
      v = idle_v();
      v.rst = (c == 0) || ($urandom_range(0, 99) < 3);
      v.if_req = if_pend; v.if_addr = ifr.if_addr;
      v.dm_req = dm_pend; v.dm_we = dmr.dm_we; v.dm_size = dmr.dm_size; v.dm_addr = dmr.dm_addr; v.dm_wdata = dmr.dm_wdata;
      v.sram_do = $urandom;
      v = model(v);
      run_vec(v, $sformatf("rand[%0d]", c));
      if (v.rst) begin
        if_pend = 0; dm_pend = 0;
      end else begin
        if (v.e_if_gnt) if_pend = 0;
        if (v.e_dm_gnt || v.e_dm_err) dm_pend = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
